// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO arbiter: FSM state encoding and request op encoding.
// Build option LIFO_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package lifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/lifo_arb_grant.sv
// Picks one eligible client per cycle and returns it one-hot and encoded.
// LIFO_ARB_RR_EN defined: search starts at i_rr_ptr; otherwise lowest index wins.
module lifo_arb_grant #(
    parameter int NUM_CLIENTS = 2,
    parameter int ID_WIDTH    = 1
) (
`ifdef LIFO_ARB_RR_EN
    input  logic [ID_WIDTH-1:0]    i_rr_ptr,
`endif
    input  logic [NUM_CLIENTS-1:0] i_eligible,
    output logic [NUM_CLIENTS-1:0] o_grant_oh,
    output logic [ID_WIDTH-1:0]    o_grant_idx,
    output logic                   o_grant_any
);

`ifdef LIFO_ARB_RR_EN
    always_comb begin
        int idx;
        idx         = 0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        // Walk the clients in rotated order; the first eligible one wins.
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = (int'(i_rr_ptr) + k) % NUM_CLIENTS;
            if (!o_grant_any && i_eligible[idx]) begin
                o_grant_any     = 1'b1;
                o_grant_idx     = ID_WIDTH'(idx);
                o_grant_oh[idx] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!o_grant_any && i_eligible[k]) begin
                o_grant_any   = 1'b1;
                o_grant_idx   = ID_WIDTH'(k);
                o_grant_oh[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between NUM_CLIENTS push/pop requesters; one LIFO op in flight at a time.
// Build option LIFO_ARB_RR_EN enables round-robin grant order (default: fixed priority).
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_CLIENTS = 2,
    localparam int ID_WIDTH    = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    input  logic [NUM_CLIENTS-1:0]            req_push,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    output logic                              rsp_valid,
    output logic [ID_WIDTH-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    input  logic                              rsp_ready,
    output logic                              lifo_write_en,
    output logic                              lifo_read_en,
    output logic [DATA_WIDTH-1:0]             lifo_data_in,
    input  logic [DATA_WIDTH-1:0]             lifo_data_out,
    input  logic                              lifo_full,
    input  logic                              lifo_empty,
    output logic                              busy
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_write_en;
    logic                    r_read_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [ID_WIDTH-1:0]     r_rsp_id;
    logic [NUM_CLIENTS-1:0]  w_eligible;
    logic [NUM_CLIENTS-1:0]  w_grant_oh;
    logic [ID_WIDTH-1:0]     w_grant_idx;
    logic                    w_grant_any;
    logic                    w_grant_push;
    logic [DATA_WIDTH-1:0]   w_grant_data;
`ifdef LIFO_ARB_RR_EN
    logic [ID_WIDTH-1:0]     r_rr_ptr;
`endif

    // Flags are only meaningful in IDLE, when no op is still in flight.
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_elig
            assign w_eligible[gi] = req_valid[gi] &
                                    ((req_push[gi] == OP_PUSH) ? !lifo_full : !lifo_empty);
        end
    endgenerate

    lifo_arb_grant #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_WIDTH    (ID_WIDTH)
    ) u_grant (
`ifdef LIFO_ARB_RR_EN
        .i_rr_ptr    (r_rr_ptr),
`endif
        .i_eligible  (w_eligible),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign w_grant_push = (req_push[w_grant_idx] == OP_PUSH);
    assign w_grant_data = req_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            r_data     <= '0;
            r_id       <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
`ifdef LIFO_ARB_RR_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            if (r_state == IDLE && w_grant_any) begin
                r_write_en <= w_grant_push;
                r_read_en  <= !w_grant_push;
                r_data     <= w_grant_data;
                r_id       <= w_grant_idx;
`ifdef LIFO_ARB_RR_EN
                r_rr_ptr   <= (w_grant_idx == ID_WIDTH'(NUM_CLIENTS-1)) ? '0
                                                                        : w_grant_idx + 1'b1;
`endif
            end
            if (r_state == WAIT) begin
                r_rsp_data <= lifo_data_out;
                r_rsp_id   <= r_id;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_any) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_write_en ? IDLE : WAIT;
            WAIT:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (r_state == IDLE) ? w_grant_oh : '0;
        rsp_valid     = (r_state == RESP);
        busy          = (r_state != IDLE);
        rsp_id        = r_rsp_id;
        rsp_data      = r_rsp_data;
        lifo_write_en = r_write_en;
        lifo_read_en  = r_read_en;
        lifo_data_in  = r_data;
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a 4-deep behavioural LIFO attached.
// Round-robin cases run only when LIFO_ARB_RR_EN is defined; fixed-priority cases otherwise.
module tb_lifo_arbiter;

    localparam int DW    = 8;
    localparam int NC    = 2;
    localparam int IW    = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NC-1:0]    req_valid = '0;
    logic [NC-1:0]    req_push = '0;
    logic [NC*DW-1:0] req_data = '0;
    logic [NC-1:0]    req_ready;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             rsp_ready = 1'b1;
    logic             lifo_write_en;
    logic             lifo_read_en;
    logic [DW-1:0]    lifo_data_in;
    logic [DW-1:0]    lifo_data_out;
    logic             lifo_full;
    logic             lifo_empty;
    logic             busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int viol = 0;

    always #5 clk = ~clk;

    lifo_arbiter #(.DATA_WIDTH(DW), .NUM_CLIENTS(NC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_push      (req_push),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .lifo_write_en (lifo_write_en),
        .lifo_read_en  (lifo_read_en),
        .lifo_data_in  (lifo_data_in),
        .lifo_data_out (lifo_data_out),
        .lifo_full     (lifo_full),
        .lifo_empty    (lifo_empty),
        .busy          (busy)
    );

    // Behavioural LIFO: registered read data, ignores overflowing/underflowing ops.
    logic [DW-1:0] mem [DEPTH];
    int            cnt;
    assign lifo_full  = (cnt == DEPTH);
    assign lifo_empty = (cnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 0;
            lifo_data_out <= '0;
        end else if (lifo_write_en && cnt < DEPTH) begin
            mem[cnt] <= lifo_data_in;
            cnt      <= cnt + 1;
        end else if (lifo_read_en && cnt > 0) begin
            lifo_data_out <= mem[cnt-1];
            cnt           <= cnt - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (lifo_write_en && lifo_read_en)  viol <= viol + 1;
            else if (lifo_write_en && lifo_full) viol <= viol + 1;
            else if (lifo_read_en && lifo_empty) viol <= viol + 1;
        end
    end

    task automatic set_req(input int c, input bit push, input logic [DW-1:0] d);
        req_valid[c]           = 1'b1;
        req_push[c]            = push;
        req_data[c*DW +: DW]   = d;
    endtask

    task automatic wait_grant(input int c, input bit hold, output bit ok, output int gcyc);
        ok   = 1'b0;
        gcyc = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (req_ready[c]) begin
                ok   = 1'b1;
                gcyc = cyc;
                $display("grant client=%0d push=%0b data=%0d cyc=%0d", c, req_push[c],
                         req_data[c*DW +: DW], cyc);
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (!hold) req_valid[c] = 1'b0;
        end
    endtask

    task automatic wait_rsp(output bit ok, output int rcyc, output logic [DW-1:0] d,
                            output logic [IW-1:0] id);
        ok   = 1'b0;
        rcyc = 0;
        d    = '0;
        id   = '0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                ok   = 1'b1;
                rcyc = cyc;
                d    = rsp_data;
                id   = rsp_id;
                $display("rsp id=%0d data=%0d cyc=%0d", id, d, cyc);
            end
        end
    endtask

    task automatic drain(output bit ok);
        bit            g_ok, r_ok;
        int            gc, rc;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        ok = 1'b1;
        for (int k = 0; k < 8 && !lifo_empty; k++) begin
            set_req(0, 1'b0, '0);
            wait_grant(0, 1'b0, g_ok, gc);
            wait_rsp(r_ok, rc, d, id);
            if (!(g_ok && r_ok)) ok = 1'b0;
        end
        if (!lifo_empty) ok = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int g;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, lifo_write_en, lifo_read_en,
             lifo_data_in, busy} !== '0)
            $display("FAIL reset_outputs: got ready=%b rv=%b we=%b re=%b busy=%b want all 0",
                     req_ready, rsp_valid, lifo_write_en, lifo_read_en, busy);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 8'h5A);
        wait_grant(0, 1'b0, ok, g);
        total_cnt++;
        if (!(ok && lifo_write_en && busy))
            $display("FAIL reset_issue_setup: got grant=%b we=%b busy=%b want 1 1 1",
                     ok, lifo_write_en, busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({lifo_write_en, lifo_read_en, req_ready, rsp_valid} !== '0)
            $display("FAIL reset_async: got we=%b re=%b ready=%b rv=%b want 0",
                     lifo_write_en, lifo_read_en, req_ready, rsp_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lifo_order();
        logic [DW-1:0] pushv [3];
        logic [DW-1:0] popv  [3];
        bit            ok, ok2;
        int            g, rc;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        pushv = '{8'd35, 8'd30, 8'd25};
        popv  = '{8'd25, 8'd30, 8'd35};
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, pushv[i]);
            wait_grant(0, 1'b0, ok, g);
            total_cnt++;
            if (!ok) $display("FAIL order_push%0d: got no grant want grant", i);
            else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b0, '0);
            wait_grant(0, 1'b0, ok, g);
            wait_rsp(ok2, rc, d, id);
            total_cnt++;
            if (!(ok && ok2) || d !== popv[i] || id !== 1'b0 || rc != g + 3)
                $display("FAIL order_pop%0d: got data=%0d id=%0d lat=%0d want data=%0d id=0 lat=3",
                         i, d, id, rc - g, popv[i]);
            else pass_cnt++;
        end
    endtask

`ifdef LIFO_ARB_RR_EN
    task automatic test_round_robin();
        int gid [4];
        int gcy [4];
        int n;
        // Fresh reset so the rotation pointer starts at client 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        set_req(0, 1'b1, 8'd10);
        set_req(1, 1'b1, 8'd20);
        for (int k = 0; k < 40 && n < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                gid[n] = req_ready[1] ? 1 : 0;
                gcy[n] = cyc;
                $display("grant client=%0d push=1 cyc=%0d", gid[n], cyc);
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (n != 4 || gid[0] != 0 || gid[1] != 1 || gid[2] != 0 || gid[3] != 1)
            $display("FAIL rr_order: got n=%0d ids=%0d%0d%0d%0d want 4 ids=0101",
                     n, gid[0], gid[1], gid[2], gid[3]);
        else pass_cnt++;
        total_cnt++;
        if (n != 4 || gcy[1] - gcy[0] != 2 || gcy[2] - gcy[1] != 2 || gcy[3] - gcy[2] != 2)
            $display("FAIL rr_spacing: got gaps %0d %0d %0d want 2 2 2",
                     gcy[1] - gcy[0], gcy[2] - gcy[1], gcy[3] - gcy[2]);
        else pass_cnt++;
        total_cnt++;
        if (cnt != 4 || mem[0] !== 8'd10 || mem[1] !== 8'd20 || mem[2] !== 8'd10 || mem[3] !== 8'd20)
            $display("FAIL rr_content: got cnt=%0d %0d %0d %0d %0d want 4 10 20 10 20",
                     cnt, mem[0], mem[1], mem[2], mem[3]);
        else pass_cnt++;
    endtask
`endif

    task automatic test_full_block();
        bit            ok, ok2, blocked;
        int            g, rc;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        drain(ok);
        total_cnt++;
        if (!ok) $display("FAIL full_drain: got cnt=%0d want 0", cnt);
        else pass_cnt++;
        for (int v = 41; v <= 44; v++) begin
            set_req(0, 1'b1, DW'(v));
            wait_grant(0, 1'b0, ok, g);
        end
        @(posedge clk);
        #1;
        total_cnt++;
        if (lifo_full !== 1'b1) $display("FAIL full_fill: got full=%b cnt=%0d want 1 4", lifo_full, cnt);
        else pass_cnt++;
        set_req(1, 1'b1, 8'd99);
        blocked = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (req_ready[1] || lifo_write_en) blocked = 1'b1;
        end
        total_cnt++;
        if (blocked) $display("FAIL full_blocked: got ready1/we high want 0 while full");
        else pass_cnt++;
        set_req(0, 1'b0, '0);
        wait_grant(0, 1'b0, ok, g);
        wait_rsp(ok2, rc, d, id);
        total_cnt++;
        if (!(ok && ok2) || d !== 8'd44 || id !== 1'b0)
            $display("FAIL full_pop_top: got data=%0d id=%0d want 44 0", d, id);
        else pass_cnt++;
        wait_grant(1, 1'b0, ok, g);
        @(posedge clk);
        #1;
        total_cnt++;
        if (!ok || cnt != 4 || mem[3] !== 8'd99)
            $display("FAIL full_c1_push: got grant=%b cnt=%0d top=%0d want 1 4 99", ok, cnt, mem[3]);
        else pass_cnt++;
    endtask

    task automatic test_empty_block();
        bit            ok, ok1, ok2, blocked;
        int            g, rc;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        drain(ok);
        total_cnt++;
        if (!ok) $display("FAIL empty_drain: got cnt=%0d want 0", cnt);
        else pass_cnt++;
        set_req(0, 1'b0, '0);
        blocked = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (req_ready[0] || lifo_read_en) blocked = 1'b1;
        end
        total_cnt++;
        if (blocked) $display("FAIL empty_blocked: got ready0/re high want 0 while empty");
        else pass_cnt++;
        set_req(1, 1'b1, 8'd7);
        wait_grant(1, 1'b0, ok1, g);
        wait_grant(0, 1'b0, ok, g);
        wait_rsp(ok2, rc, d, id);
        total_cnt++;
        if (!(ok1 && ok && ok2) || d !== 8'd7 || id !== 1'b0)
            $display("FAIL empty_then_pop: got data=%0d id=%0d want 7 0", d, id);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit            ok, ok2, stable;
        int            g, rc;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        set_req(0, 1'b1, 8'd55);
        wait_grant(0, 1'b0, ok, g);
        rsp_ready = 1'b0;
        set_req(0, 1'b0, '0);
        wait_grant(0, 1'b0, ok2, g);
        set_req(1, 1'b1, 8'd66);
        wait_rsp(ok, rc, d, id);
        total_cnt++;
        if (!(ok && ok2) || d !== 8'd55 || id !== 1'b0)
            $display("FAIL bp_rsp: got data=%0d id=%0d want 55 0", d, id);
        else pass_cnt++;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || rsp_data !== 8'd55 || rsp_id !== 1'b0 || req_ready !== '0 || lifo_write_en)
                stable = 1'b0;
        end
        total_cnt++;
        if (!stable)
            $display("FAIL bp_hold: got rv=%b data=%0d ready=%b want 1 55 00", rsp_valid, rsp_data, req_ready);
        else pass_cnt++;
        rsp_ready = 1'b1;
        wait_grant(1, 1'b0, ok, g);
        total_cnt++;
        if (!ok) $display("FAIL bp_release: got no grant for client 1 want grant");
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

`ifndef LIFO_ARB_RR_EN
    task automatic test_fixed_priority();
        bit ok;
        int n, c1n;
        drain(ok);
        n   = 0;
        c1n = 0;
        set_req(0, 1'b1, 8'd1);
        set_req(1, 1'b1, 8'd2);
        for (int k = 0; k < 40 && n < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                $display("grant client=%0d push=1 cyc=%0d", req_ready[1] ? 1 : 0, cyc);
                if (req_ready[1]) c1n++;
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        total_cnt++;
        if (!ok || n != 3 || c1n != 0)
            $display("FAIL fixed_prio: got grants=%0d c1_grants=%0d want 3 0", n, c1n);
        else pass_cnt++;
    endtask
`endif

    task automatic test_protocol();
        @(posedge clk);
        #1;
        total_cnt++;
        if (viol != 0) $display("FAIL lifo_protocol: got %0d violations want 0", viol);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lifo_order();
`ifdef LIFO_ARB_RR_EN
        test_round_robin();
`endif
        test_full_block();
        test_empty_block();
        test_backpressure();
`ifndef LIFO_ARB_RR_EN
        test_fixed_priority();
`endif
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
